// File: rtl/uart_tx_fifo_if.sv
// Byte-FIFO bus between the CPU store path, the UART register block and the
// UART transmitter. The master side is the environment (CPU writes and the
// transmitter's busy level); the slave side is the FIFO itself.
interface uart_tx_fifo_if #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DWIDTH-1:0] wr_data;
  logic              clr_ovf;
  logic              tx_busy;
  logic              tx_start;
  logic [DWIDTH-1:0] d_tx;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              overflow;

  modport master (
    output wr_en, wr_data, clr_ovf, tx_busy,
    input  tx_start, d_tx, full, empty, count, overflow
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf, tx_busy,
    output tx_start, d_tx, full, empty, count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO for the UART. The CPU can burst-write up to DEPTH bytes. A
// small FSM pops one byte at a time and hands it to the transmitter with a
// start/busy handshake. The FIFO reports full/empty/count and a sticky
// overflow flag to the register block.
module uart_tx_fifo #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t            state_q;
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              tx_start_q;
  logic [DWIDTH-1:0] d_tx_q;

  logic full_w, empty_w, push, drop, pop;

  // Flags come from the registered count, so they describe the pre-pop
  // occupancy. A write into a full FIFO is dropped even when a pop happens
  // in the same cycle.
  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);
  assign push    = bus.wr_en & ~full_w;
  assign drop    = bus.wr_en & full_w;
  assign pop     = (state_q == IDLE) & ~empty_w & ~bus.tx_busy;

  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
  assign bus.tx_start = tx_start_q;
  assign bus.d_tx     = d_tx_q;

  // Next-state for pointers, occupancy and the sticky overflow flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A dropped write wins over a clear in the same cycle
    if (drop)             ovf_d = 1'b1;
    else if (bus.clr_ovf) ovf_d = 1'b0;
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  // Pointer, count and overflow registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Transmit handshake FSM with registered tx_start/d_tx. At most one byte is
  // in flight. d_tx only changes on a pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      d_tx_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            d_tx_q  <= mem_q[rd_ptr_q];
            state_q <= LOAD;
          end
        end
        LOAD: begin
          tx_start_q <= 1'b1;
          state_q    <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // Transmitter ticks are slow; wait as long as it takes
          if (bus.tx_busy) begin
            tx_start_q <= 1'b0;
            state_q    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) state_q <= IDLE;
        end
        default: begin
          tx_start_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end
endmodule
